// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg
// Shared constants and helpers for the FIFO read-side stream adapter.
//   SKID_DEPTH         : entries in the read-latency skid buffer (3)
//   IDX_W              : width of the buffer write/read indices (2)
//   CNT_W              : width of the buffer occupancy count (2)
//   DEFAULT_DATA_WIDTH : default FIFO/stream data width (8)
// ----------------------------------------------------------------------------
package fifo_pkg;

    localparam int SKID_DEPTH         = 3;
    localparam int IDX_W              = 2;
    localparam int CNT_W              = 2;
    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [CNT_W-1:0] cnt_t;

    // Advance a buffer index, wrapping from the last entry back to 0.
    function automatic idx_t idx_inc(input idx_t i);
        if (i == idx_t'(SKID_DEPTH - 1)) begin
            return '0;
        end
        return idx_t'(i + idx_t'(1));
    endfunction

endpackage

// File: rtl/fifo_rd_buf.sv
// ----------------------------------------------------------------------------
// fifo_rd_buf
// Three-entry circular buffer that absorbs words already requested from the
// FIFO. Holds storage plus the wrapping write/read indices; occupancy
// tracking lives in the parent.
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset (indices only)
//   wr_en    in   store wr_data at the write index and advance it
//   wr_data  in   word to store
//   rd_en    in   advance the read index (word consumed)
//   rd_data  out  word at the read index
// ----------------------------------------------------------------------------
module fifo_rd_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [SKID_DEPTH];
    idx_t                  wr_idx_q, wr_idx_d;
    idx_t                  rd_idx_q, rd_idx_d;

    always_comb begin
        mem_d    = mem_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        if (wr_en) begin
            mem_d[wr_idx_q] = wr_data;
            wr_idx_d        = idx_inc(wr_idx_q);
        end
        if (rd_en) begin
            rd_idx_d = idx_inc(rd_idx_q);
        end
    end

    // Storage carries no reset: contents are meaningless until the parent's
    // occupancy count says otherwise.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
        end else begin
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
        end
    end

    assign rd_data = mem_q[rd_idx_q];

endmodule

// File: rtl/fifo_rd_stream.sv
// ----------------------------------------------------------------------------
// fifo_rd_stream
// Converts an async-FIFO read port (read enable / empty / data with one clock
// of read latency) into a valid/ready stream without loss or duplication.
// A read is only issued when the skid buffer is guaranteed to have room for
// the returning word, so fifo_ren never depends on m_ready combinationally.
// Optional feature: define FIFO_RD_CNT_EN to add the m_count port, a
// counter of delivered words that wraps at 2^CNT_WIDTH.
// Ports:
//   clk         in   read-domain clock
//   rst         in   synchronous active-high reset
//   fifo_empty  in   FIFO empty flag
//   fifo_rdata  in   FIFO read data, valid one clock after fifo_ren
//   fifo_ren    out  FIFO read enable
//   m_valid     out  stream word valid
//   m_ready     in   downstream accepts word
//   m_data      out  stream word
//   m_count     out  words delivered (FIFO_RD_CNT_EN only)
// ----------------------------------------------------------------------------
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_ren,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RD_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  m_count
`endif
);

    cnt_t       count_q, count_d;
    logic       inflight_q, inflight_d;
    logic       capture;
    logic       pop;
    logic [2:0] occupancy;

    // Buffered words plus the one still in the FIFO's read pipeline; a new
    // read is only allowed while that total leaves room for its return.
    always_comb begin
        occupancy = {1'b0, count_q} + {2'b00, inflight_q};
        fifo_ren  = !rst && !fifo_empty && (occupancy < 3'(SKID_DEPTH));
    end

    always_comb begin
        m_valid = !rst && (count_q != '0);
        capture = inflight_q;
        pop     = m_valid && m_ready;
    end

    always_comb begin
        inflight_d = fifo_ren;
        count_d    = count_q;
        unique case ({capture, pop})
            2'b10:   count_d = cnt_t'(count_q + cnt_t'(1));
            2'b01:   count_d = cnt_t'(count_q - cnt_t'(1));
            default: count_d = count_q;
        endcase
    end

    // Reset drops buffered and in-flight words; the FIFO is reset alongside.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            inflight_q <= inflight_d;
        end
    end

    fifo_rd_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (capture),
        .wr_data (fifo_rdata),
        .rd_en   (pop),
        .rd_data (m_data)
    );

`ifdef FIFO_RD_CNT_EN
    logic [CNT_WIDTH-1:0] m_count_q, m_count_d;

    always_comb begin
        m_count_d = m_count_q;
        if (pop) begin
            m_count_d = m_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_count_q <= '0;
        end else begin
            m_count_q <= m_count_d;
        end
    end

    assign m_count = m_count_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// ----------------------------------------------------------------------------
// tb_fifo_rd_stream
// Directed bench for fifo_rd_stream. A behavioural FIFO feeds the DUT with
// one clock of read latency; every word pushed into the FIFO is also queued
// as an expected stream word, and a monitor pops and compares each accepted
// stream word. Build with FIFO_RD_CNT_EN defined to also exercise m_count.
// ----------------------------------------------------------------------------
module tb_fifo_rd_stream;

    localparam int DW = 8;
`ifdef FIFO_RD_CNT_EN
    localparam int CW = 4;
`else
    localparam int CW = 16;
`endif

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_rdata = 8'hEE;
    logic          m_ready    = 1'b0;
    logic          fifo_ren;
    logic          m_valid;
    logic [DW-1:0] m_data;
`ifdef FIFO_RD_CNT_EN
    logic [CW-1:0] m_count;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [DW-1:0] fifo_q [$];
    logic [DW-1:0] exp_q  [$];

    fifo_rd_stream #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_ren   (fifo_ren),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
`ifdef FIFO_RD_CNT_EN
        ,
        .m_count    (m_count)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stimulus drives 1 time unit after the falling edge and samples at +3.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic probe();
        #2;
    endtask

    task automatic push(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic wait_valid(input string name, input int limit);
        int n;
        n = 0;
        while (!m_valid && n < limit) begin
            step();
            probe();
            n++;
        end
        check({name, "_valid_seen"}, 32'(m_valid), 32'd1);
    endtask

    task automatic drain(input string name, input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            step();
            probe();
            n++;
        end
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Behavioural FIFO: empty flag updates on the falling edge, a read is
    // decided just before the rising edge, data appears after that edge.
    initial begin : fifo_model
        logic          pend;
        logic [DW-1:0] pend_w;
        pend   = 1'b0;
        pend_w = '0;
        forever begin
            @(negedge clk);
            fifo_rdata = pend ? pend_w : 8'hEE;
            pend       = 1'b0;
            fifo_empty = (fifo_q.size() == 0);
            #4;
            if (fifo_ren) begin
                check("ren_when_empty", 32'(fifo_q.size() != 0), 32'd1);
                if (fifo_q.size() != 0) begin
                    pend_w = fifo_q.pop_front();
                    pend   = 1'b1;
                end
            end
        end
    end

    // Scoreboard monitor: compares every accepted stream word.
    initial begin : monitor
        forever begin
            @(negedge clk);
            #4;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected actual=%0h required=none", m_data);
                end else begin
                    check("sb_data", 32'(m_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int c0;
        int pulses;

        // Reset held with data in the FIFO: nothing may move.
        rst     = 1'b1;
        m_ready = 1'b0;
        step();
        for (int i = 1; i <= 8; i++) push(8'(i));
        for (int i = 0; i < 3; i++) begin
            step();
            probe();
            check("rst_ren", 32'(fifo_ren), 32'd0);
            check("rst_valid", 32'(m_valid), 32'd0);
        end

        // Release: read on the first cycle, first word two edges later,
        // then one word per clock.
        step();
        rst     = 1'b0;
        m_ready = 1'b1;
        probe();
        check("ren_after_rst", 32'(fifo_ren), 32'd1);
        c0 = cyc;
        wait_valid("stream", 10);
        check("stream_latency", 32'(cyc - c0), 32'd2);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                step();
                probe();
            end
            check("stream_valid", 32'(m_valid), 32'd1);
            check("stream_data", 32'(m_data), 32'(i + 1));
        end
        step();
        probe();
        check("stream_end_valid", 32'(m_valid), 32'd0);

        // Backpressure: only three reads may be issued while blocked.
        step();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'(8'h11 + i));
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            probe();
            if (fifo_ren) pulses++;
        end
        check("bp_ren_pulses", 32'(pulses), 32'd3);
        check("bp_count", 32'(dut.count_q), 32'd3);
        check("bp_valid", 32'(m_valid), 32'd1);
        check("bp_data", 32'(m_data), 32'h11);
        step();
        probe();
        check("bp_data_stable", 32'(m_data), 32'h11);
        check("bp_ren_idle", 32'(fifo_ren), 32'd0);
        step();
        m_ready = 1'b1;
        drain("bp", 20);
        step();
        probe();
        check("bp_idle_valid", 32'(m_valid), 32'd0);

        // Wrap: ten words with a toggling consumer.
        step();
        for (int i = 0; i < 10; i++) push(8'(8'h30 + i));
        for (int i = 0; i < 30; i++) begin
            step();
            m_ready = (i % 2 == 0);
        end
        step();
        m_ready = 1'b1;
        drain("wrap", 30);

        // Empty boundary: two words, then the FIFO runs dry.
        step();
        push(8'h41);
        push(8'h42);
        probe();
        wait_valid("eb", 10);
        check("eb_data0", 32'(m_data), 32'h41);
        step();
        probe();
        check("eb_valid1", 32'(m_valid), 32'd1);
        check("eb_data1", 32'(m_data), 32'h42);
        step();
        probe();
        check("eb_valid_drop", 32'(m_valid), 32'd0);
        check("eb_ren", 32'(fifo_ren), 32'd0);
        check("eb_inflight", 32'(dut.inflight_q), 32'd0);

`ifdef FIFO_RD_CNT_EN
        // Counter: clear, 17 pops wrap a 4-bit count to 1, then reset mid-stream.
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        probe();
        check("cnt_cleared", 32'(m_count), 32'd0);
        for (int i = 0; i < 17; i++) push(8'(8'h60 + i));
        drain("cnt", 60);
        step();
        probe();
        check("cnt_wrap", 32'(m_count), 32'd1);
        for (int i = 0; i < 6; i++) push(8'(8'h80 + i));
        wait_valid("cnt_mid", 10);
        step();
        rst = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        probe();
        check("cnt_rst_valid", 32'(m_valid), 32'd0);
        step();
        probe();
        check("cnt_rst_count", 32'(m_count), 32'd0);
        check("cnt_rst_valid_next", 32'(m_valid), 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            probe();
        end
        check("cnt_post_rst_valid", 32'(m_valid), 32'd0);
        check("cnt_post_rst_count", 32'(m_count), 32'd0);
`endif

        step();
        probe();
        check("sb_all_consumed", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
